// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared encodings for the multicycle RISC-V control path: FSM state enum,
// internal alu_op codes, opcode constants, mux-select encodings for
// result_src / alu_src_a / alu_src_b / imm_src, and the ALU operation codes
// produced by aludec.
package riscv_pkg;

    // Multicycle controller states
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // alu_op: what the FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Opcodes understood by the controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // result_src selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_a selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // alu_src_b selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // imm_src selects
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/aludec.sv
// aludec
// Combinational ALU decoder.
// Ports:
//   alu_op      in  2  request from the FSM (add / sub / decode funct fields)
//   funct3      in  3  instruction funct3
//   funct7b5    in  1  instruction bit 30
//   op5         in  1  opcode bit 5 (1 = R-type, 0 = I-type for ALU ops)
//   alu_control out 4  ALU operation code
module aludec
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alu_control
);

    // Fixed add/sub for address and compare work; full funct3 decode for
    // arithmetic. Bit 30 selects SUB only for R-type, because in addi it is
    // just an immediate bit; for shifts it always picks arithmetic shift.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Moore FSM controller for a multicycle RISC-V datapath (lw/sw/R/I/beq/bne/jal).
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   op, funct3, funct7b5 instruction fields
//   zero                ALU zero flag (branch resolve)
//   mem_ready           one-cycle memory completion strobe
//   pc_write, adr_src, mem_write, ir_write, reg_write    datapath enables/selects
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control mux selects / ALU op
//   trap                illegal-instruction halt indicator
module mc_controller
    import riscv_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic       trap
);

    state_t     state, next_state;
    logic [1:0] alu_op;
    logic       illegal;
    logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, trap_raw;

    // State register; reset lands in FETCH straight away, no clock needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    // Encodings we refuse to execute: unknown opcodes, branches other than
    // BEQ/BNE, and loads/stores other than word width
    always_comb begin
        illegal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE: illegal = (funct3 != 3'b010);
            OP_BRANCH:         illegal = (funct3[2:1] != 2'b00);
            OP_RTYPE, OP_ITYPE, OP_JAL: illegal = 1'b0;
            default:           illegal = 1'b1;
        endcase
    end

    // Next-state and per-state outputs. FETCH's pc/ir enables follow
    // mem_ready so the instruction is latched on the completing cycle;
    // BRANCH resolves BEQ vs BNE by flipping the zero flag with funct3[0].
    always_comb begin
        next_state    = state;
        pc_write_raw  = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        trap_raw      = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                pc_write_raw = mem_ready;
                ir_write_raw = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (illegal) begin
                    next_state = HALT_ON_ILLEGAL ? TRAP : FETCH;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: next_state = MEMADR;
                        OP_RTYPE:          next_state = EXECR;
                        OP_ITYPE:          next_state = EXECI;
                        OP_BRANCH:         next_state = BRANCH;
                        OP_JAL:            next_state = JAL;
                        default:           next_state = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_op       = ALUOP_SUB;
                pc_write_raw = zero ^ funct3[0];
                next_state   = FETCH;
            end
            JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
                next_state   = ALUWB;
            end
            TRAP: begin
                trap_raw = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // Write enables are forced low while reset is held, even in FETCH with
    // mem_ready high, so nothing in the datapath commits during reset
    assign pc_write  = pc_write_raw  & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign trap      = trap_raw      & rst_n;

    // Immediate format follows the opcode in every state
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

    aludec u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Directed bench for mc_controller. Stimulus drives instruction fields one
// cycle at a time and queues the hand-derived expected output vector for
// that cycle; a monitor pops and compares on each falling clock edge (or
// on demand, for checks that must happen between clock edges).
module tb_mc_controller;

    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] OPLW = 7'b0000011;
    localparam logic [6:0] OPSW = 7'b0100011;
    localparam logic [6:0] OPBR = 7'b1100011;
    localparam logic [6:0] OPJ  = 7'b1101111;
    localparam logic [6:0] OPX  = 7'b1111111;

    logic       clk, rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0] alu_control;

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    event sampleEv;

    mc_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .trap        (trap)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate format expected from the opcode alone
    function automatic logic [1:0] immFor(input logic [6:0] o);
        case (o)
            OPSW:    return 2'b01;
            OPBR:    return 2'b10;
            OPJ:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Output vector for a state, packed as
    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
    //  alu_src_a, alu_src_b, imm_src, alu_control, trap}
    function automatic logic [17:0] expVec(input string st, input logic pcw,
                                           input logic [1:0] imm, input logic [3:0] aluc);
        logic adr, mw, irw, rw, tr;
        logic [1:0] rs, sa, sb;
        adr = 0; mw = 0; irw = 0; rw = 0; tr = 0; rs = 2'b00; sa = 2'b00; sb = 2'b00;
        case (st)
            "FETCH":    begin rs = 2'b10; sb = 2'b10; irw = pcw; end
            "DECODE":   begin sa = 2'b01; sb = 2'b01; end
            "MEMADR":   begin sa = 2'b10; sb = 2'b01; end
            "MEMREAD":  begin adr = 1; end
            "MEMWB":    begin rs = 2'b01; rw = 1; end
            "MEMWRITE": begin adr = 1; mw = 1; end
            "EXECR":    begin sa = 2'b10; end
            "EXECI":    begin sa = 2'b10; sb = 2'b01; end
            "ALUWB":    begin rw = 1; end
            "BRANCH":   begin sa = 2'b10; end
            "JAL":      begin sa = 2'b01; sb = 2'b10; end
            "TRAP":     begin tr = 1; end
            default:    begin tr = 1'bx; end
        endcase
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, aluc, tr};
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue what the
    // DUT must show for that cycle
    task automatic applyStimulus(input string tag, input string st, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7, input logic z,
                                 input logic mr, input logic pcw, input logic [3:0] aluc);
        exp_t e;
        @(posedge clk);
        #1;
        op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = mr;
        e.tag = tag;
        e.v   = expVec(st, pcw, immFor(o), aluc);
        expQ.push_back(e);
    endtask

    // Queue an expectation and have the monitor check it right now
    task automatic checkNow(input string tag, input string st, input logic pcw,
                            input logic [3:0] aluc);
        exp_t e;
        e.tag = tag;
        e.v   = expVec(st, pcw, immFor(op), aluc);
        expQ.push_back(e);
        ->sampleEv;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [17:0] got;
        got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, trap};
        total++;
        if (got !== e.v) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b", e.tag, got, e.v);
        end
    endtask

    // Monitor: compares on every falling edge, or when a mid-cycle check fires
    always begin
        @(negedge clk or sampleEv);
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Assert reset between clock edges, check outputs before any edge, release
    task automatic midCycleReset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkNow(tag, "FETCH", 1'b0, 4'b0010);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0; op = OPR; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        $display("[TB] starting mc_controller bench");

        // Reset held with mem_ready high: FETCH selects, enables gated off
        applyStimulus("reset", "FETCH", OPR, 3'b000, 0, 0, 1, 0, 4'b0010);
        #2 rst_n = 1'b1; mem_ready = 1'b0;

        // add x3,x1,x2
        applyStimulus("add-wait",   "FETCH", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);
        applyStimulus("add-fetch",  "FETCH", OPR, 3'b000, 0, 0, 1, 1, 4'b0010);
        applyStimulus("add-decode", "DECODE", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);
        applyStimulus("add-exec",   "EXECR", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);
        applyStimulus("add-wb",     "ALUWB", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);

        // sub
        applyStimulus("sub-fetch",  "FETCH", OPR, 3'b000, 1, 0, 1, 1, 4'b0010);
        applyStimulus("sub-decode", "DECODE", OPR, 3'b000, 1, 0, 0, 0, 4'b0010);
        applyStimulus("sub-exec",   "EXECR", OPR, 3'b000, 1, 0, 0, 0, 4'b0011);
        applyStimulus("sub-wb",     "ALUWB", OPR, 3'b000, 1, 0, 0, 0, 4'b0010);

        // addi with bit30 set still adds
        applyStimulus("addi-fetch",  "FETCH", OPI, 3'b000, 1, 0, 1, 1, 4'b0010);
        applyStimulus("addi-decode", "DECODE", OPI, 3'b000, 1, 0, 0, 0, 4'b0010);
        applyStimulus("addi-exec",   "EXECI", OPI, 3'b000, 1, 0, 0, 0, 4'b0010);
        applyStimulus("addi-wb",     "ALUWB", OPI, 3'b000, 1, 0, 0, 0, 4'b0010);

        // srai
        applyStimulus("srai-fetch",  "FETCH", OPI, 3'b101, 1, 0, 1, 1, 4'b0010);
        applyStimulus("srai-decode", "DECODE", OPI, 3'b101, 1, 0, 0, 0, 4'b0010);
        applyStimulus("srai-exec",   "EXECI", OPI, 3'b101, 1, 0, 0, 0, 4'b0111);
        applyStimulus("srai-wb",     "ALUWB", OPI, 3'b101, 1, 0, 0, 0, 4'b0010);

        // lw with memory stalling three cycles in MEMREAD
        applyStimulus("lw-fetch",  "FETCH", OPLW, 3'b010, 0, 0, 1, 1, 4'b0010);
        applyStimulus("lw-decode", "DECODE", OPLW, 3'b010, 0, 0, 0, 0, 4'b0010);
        applyStimulus("lw-adr",    "MEMADR", OPLW, 3'b010, 0, 0, 0, 0, 4'b0010);
        for (int i = 0; i < 3; i++)
            applyStimulus("lw-stall", "MEMREAD", OPLW, 3'b010, 0, 0, 0, 0, 4'b0010);
        applyStimulus("lw-read",   "MEMREAD", OPLW, 3'b010, 0, 0, 1, 0, 4'b0010);
        applyStimulus("lw-wb",     "MEMWB", OPLW, 3'b010, 0, 0, 0, 0, 4'b0010);

        // sw, memory ready at once
        applyStimulus("sw-fetch",  "FETCH", OPSW, 3'b010, 0, 0, 1, 1, 4'b0010);
        applyStimulus("sw-decode", "DECODE", OPSW, 3'b010, 0, 0, 0, 0, 4'b0010);
        applyStimulus("sw-adr",    "MEMADR", OPSW, 3'b010, 0, 0, 0, 0, 4'b0010);
        applyStimulus("sw-write",  "MEMWRITE", OPSW, 3'b010, 0, 0, 1, 0, 4'b0010);

        // beq / bne, both zero polarities
        applyStimulus("beq1-fetch",  "FETCH", OPBR, 3'b000, 0, 1, 1, 1, 4'b0010);
        applyStimulus("beq1-decode", "DECODE", OPBR, 3'b000, 0, 1, 0, 0, 4'b0010);
        applyStimulus("beq1-branch", "BRANCH", OPBR, 3'b000, 0, 1, 0, 1, 4'b0011);
        applyStimulus("beq0-fetch",  "FETCH", OPBR, 3'b000, 0, 0, 1, 1, 4'b0010);
        applyStimulus("beq0-decode", "DECODE", OPBR, 3'b000, 0, 0, 0, 0, 4'b0010);
        applyStimulus("beq0-branch", "BRANCH", OPBR, 3'b000, 0, 0, 0, 0, 4'b0011);
        applyStimulus("bne1-fetch",  "FETCH", OPBR, 3'b001, 0, 1, 1, 1, 4'b0010);
        applyStimulus("bne1-decode", "DECODE", OPBR, 3'b001, 0, 1, 0, 0, 4'b0010);
        applyStimulus("bne1-branch", "BRANCH", OPBR, 3'b001, 0, 1, 0, 0, 4'b0011);
        applyStimulus("bne0-fetch",  "FETCH", OPBR, 3'b001, 0, 0, 1, 1, 4'b0010);
        applyStimulus("bne0-decode", "DECODE", OPBR, 3'b001, 0, 0, 0, 0, 4'b0010);
        applyStimulus("bne0-branch", "BRANCH", OPBR, 3'b001, 0, 0, 0, 1, 4'b0011);

        // jal
        applyStimulus("jal-fetch",  "FETCH", OPJ, 3'b000, 0, 0, 1, 1, 4'b0010);
        applyStimulus("jal-decode", "DECODE", OPJ, 3'b000, 0, 0, 0, 0, 4'b0010);
        applyStimulus("jal-jump",   "JAL", OPJ, 3'b000, 0, 0, 0, 1, 4'b0010);
        applyStimulus("jal-wb",     "ALUWB", OPJ, 3'b000, 0, 0, 0, 0, 4'b0010);

        // Reset in the middle of a stalled store
        applyStimulus("swr-fetch",  "FETCH", OPSW, 3'b010, 0, 0, 1, 1, 4'b0010);
        applyStimulus("swr-decode", "DECODE", OPSW, 3'b010, 0, 0, 0, 0, 4'b0010);
        applyStimulus("swr-adr",    "MEMADR", OPSW, 3'b010, 0, 0, 0, 0, 4'b0010);
        applyStimulus("swr-wait1",  "MEMWRITE", OPSW, 3'b010, 0, 0, 0, 0, 4'b0010);
        applyStimulus("swr-wait2",  "MEMWRITE", OPSW, 3'b010, 0, 0, 0, 0, 4'b0010);
        midCycleReset("swr-async-reset");
        applyStimulus("swr-restart", "FETCH", OPR, 3'b000, 0, 0, 1, 1, 4'b0010);
        applyStimulus("swr-decode2", "DECODE", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);
        applyStimulus("swr-exec",    "EXECR", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);
        applyStimulus("swr-wb",      "ALUWB", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);

        // Undefined opcode halts in TRAP until reset
        applyStimulus("ill-fetch",  "FETCH", OPX, 3'b000, 0, 0, 1, 1, 4'b0010);
        applyStimulus("ill-decode", "DECODE", OPX, 3'b000, 0, 0, 1, 0, 4'b0010);
        for (int i = 0; i < 11; i++)
            applyStimulus("ill-trap", "TRAP", OPX, 3'b000, 0, 0, 1, 0, 4'b0010);
        midCycleReset("ill-reset");

        // Branch with unsupported funct3 also traps
        applyStimulus("illb-fetch",  "FETCH", OPBR, 3'b100, 0, 0, 1, 1, 4'b0010);
        applyStimulus("illb-decode", "DECODE", OPBR, 3'b100, 0, 0, 0, 0, 4'b0010);
        applyStimulus("illb-trap1",  "TRAP", OPBR, 3'b100, 0, 0, 0, 0, 4'b0010);
        applyStimulus("illb-trap2",  "TRAP", OPBR, 3'b100, 0, 0, 0, 0, 4'b0010);
        midCycleReset("illb-reset");
        applyStimulus("post-fetch",  "FETCH", OPR, 3'b000, 0, 0, 1, 1, 4'b0010);
        applyStimulus("post-decode", "DECODE", OPR, 3'b000, 0, 0, 0, 0, 4'b0010);

        // Let the monitor drain; anything left unchecked is a failure
        for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL provide parameter: HALT_ON_ILLEGAL, default 1, 1 = enter TRAP on illegal encoding, 0 = treat it as NOP and return to FETCH.
REQ-002 SHALL provide port: clk  input  1  single system clock, rising-edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide inputs:
- op  input  7  instruction opcode.
- funct3  input  3  instruction funct3.
- funct7b5  input  1  instruction bit 30.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  one-cycle memory-access-complete strobe.
REQ-005 SHALL provide outputs:
- pc_write  output  1  PC register enable.
- adr_src  output  1  0 = PC, 1 = ALU result.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register enable.
- reg_write  output  1  register file write enable.
- result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1.
- alu_src_b  output  2  00 rs2, 01 imm, 10 constant 4.
- imm_src  output  2  00 I, 01 S, 10 B, 11 J.
- alu_control  output  4  ALU operation code.
- trap  output  1  illegal-instruction halt indicator.

Function
REQ-006 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP; every output not listed for a state SHALL be 0.
REQ-007 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, with ir_write=pc_write=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-008 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00, and SHALL branch on op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- other opcodes -> illegal.
REQ-009 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00, then go to MEMREAD if op[5]=0, else MEMWRITE.
REQ-010 MEMREAD SHALL drive adr_src=1, result_src=00, hold until mem_ready=1, then go to MEMWB.
REQ-011 MEMWB SHALL drive result_src=01, reg_write=1, then go to FETCH.
REQ-012 MEMWRITE SHALL drive adr_src=1, result_src=00, mem_write=1, hold until mem_ready=1, then go to FETCH; mem_write SHALL stay high every cycle of the wait.
REQ-013 EXECR SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10; EXECI SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10; both SHALL go to ALUWB.
REQ-014 ALUWB SHALL drive result_src=00, reg_write=1, then go to FETCH.
REQ-015 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, with pc_write = zero XOR funct3[0] (BEQ/BNE), then go to FETCH.
REQ-016 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then go to ALUWB.
REQ-017 An illegal encoding SHALL be any of:
- an undefined opcode;
- a branch with funct3 not 000/001;
- a load/store with funct3 not 010.
REQ-018 On an illegal encoding in DECODE:
- HALT_ON_ILLEGAL=1: SHALL go to TRAP; TRAP SHALL assert trap=1 with all enables 0 and remain until reset.
- HALT_ON_ILLEGAL=0: SHALL go to FETCH.
REQ-019 imm_src SHALL be combinational from op in every state:
- lw/I-type -> 00.
- sw -> 01.
- branch -> 10.
- jal -> 11.
- other opcodes -> 00.
REQ-020 alu_control SHALL be combinational from alu_op, funct3, funct7b5 and op[5]:
- alu_op 00 -> ADD 0010.
- alu_op 01 -> SUB 0011.
- alu_op 10 -> full funct3 decode, with SUB only when op[5]=1 and funct7b5=1.
REQ-021 Cycle counts SHALL be, assuming mem_ready on the first eligible cycle:
- R/I: 4.
- lw: 5.
- sw: 4.
- branch: 3.
- jal: 4.

Reset
REQ-022 rst_n low SHALL force state=FETCH immediately, regardless of the clock and of any in-progress access.
REQ-023 While rst_n is low, all write enables (pc_write, ir_write, reg_write, mem_write) and trap SHALL be 0.
REQ-024 The first FETCH SHALL occur on the first clk edge after rst_n deasserts.

Structure
REQ-025 State enum, alu_op encodings, opcode constants and the result_src/alu_src/imm_src encodings SHALL live in shared package riscv_pkg.
REQ-026 The alu_control decode SHALL be the existing sub-module aludec, instantiated once; the FSM and imm_src decode SHALL stay in mc_controller.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; alu_control 0010 in EXECR; reg_write=1 in ALUWB only.
- sub (f7b5=1) -> alu_control 0011; addi with f7b5=1 -> 0010; srai (op 0010011, f3 101, f7b5 1) -> 0111.
- lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src=01, reg_write=1.
- beq: zero=1 -> pc_write=1 in BRANCH; zero=0 -> 0; bne inverts both cases.
- Opcode 1111111 with HALT_ON_ILLEGAL=1 -> TRAP, trap=1 for 10+ cycles, no enables; rst_n low -> FETCH.
- rst_n asserted mid-MEMWRITE -> mem_write drops to 0 without a clk edge; restart at FETCH.
